// File: rtl/conv_axil_pkg.sv
// rtl/conv_axil_pkg.sv - shared constants and FSM encodings for the AXI4-Lite responder
package conv_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int         NUM_REGS    = 16;
  localparam int         NUM_RW_REGS = 14;
  localparam logic [3:0] REG_CNT_IDX = 4'd14;
  localparam logic [3:0] REG_ID_IDX  = 4'd15;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/conv_axil_regfile.sv
// rtl/conv_axil_regfile.sv - 16x32 register file: 14 strobed RW regs, write counter, ID word
import conv_axil_pkg::*;

module conv_axil_regfile #(
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [31:0]                 wr_data,
  input  logic [3:0]                  wr_strb,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [31:0]                 rd_data
);

  logic [31:0] rw_regs [NUM_RW_REGS];
  logic [31:0] wr_count;

  // Byte-lane write into the RW bank; every accepted RW write bumps the counter, even with no strobes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        rw_regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_en && (wr_idx < REG_CNT_IDX)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          rw_regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      wr_count <= wr_count + 32'd1;
    end
  end

  // Combinational read port; the top samples it on the AR handshake edge
  always_comb begin
    rd_data = '0;
    if (rd_idx == REG_ID_IDX) begin
      rd_data = ID_VALUE;
    end else if (rd_idx == REG_CNT_IDX) begin
      rd_data = wr_count;
    end else begin
      rd_data = rw_regs[rd_idx];
    end
  end

endmodule

// File: rtl/conv_axil_responder.sv
// rtl/conv_axil_responder.sv - AXI4-Lite responder with independent write and read FSMs
import conv_axil_pkg::*;

module conv_axil_responder #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] ID_VALUE           = 32'hC0DE_0001
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  wr_state_e   w_state, w_state_next;
  rd_state_e   r_state, r_state_next;
  logic        out_of_reset;
  logic        aw_latched, w_latched;
  logic [3:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit, wr_err;
  logic [3:0]  wr_idx, rd_idx;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic        unused_inputs;

  // READY is held off until the first edge after reset release so nothing is accepted during reset
  assign S_AXI_AWREADY = out_of_reset && (w_state == W_IDLE) && !aw_latched;
  assign S_AXI_WREADY  = out_of_reset && (w_state == W_IDLE) && !w_latched;
  assign S_AXI_ARREADY = out_of_reset && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx = S_AXI_ARADDR[5:2];
  assign wr_err = (wr_idx >= REG_CNT_IDX);

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // State registers for both channels plus the post-reset READY enable
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state      <= W_IDLE;
      r_state      <= R_IDLE;
      out_of_reset <= 1'b0;
    end else begin
      w_state      <= w_state_next;
      r_state      <= r_state_next;
      out_of_reset <= 1'b1;
    end
  end

  // Write next-state: commit on the edge where the later of AW/W completes, using live or latched values
  always_comb begin
    w_state_next = w_state;
    wr_commit    = 1'b0;
    wr_idx       = aw_hs ? S_AXI_AWADDR[5:2] : aw_idx_q;
    wr_data      = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb      = w_hs ? S_AXI_WSTRB : wstrb_q;
    case (w_state)
      W_IDLE: begin
        if ((aw_latched || aw_hs) && (w_latched || w_hs)) begin
          wr_commit    = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Independent AW/W latches, response code capture, and latch release on the B handshake
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_idx_q   <= S_AXI_AWADDR[5:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        wdata_q   <= S_AXI_WDATA;
        wstrb_q   <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if ((w_state == W_RESP) && S_AXI_BREADY) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
      end
    end
  end

  // Read next-state: one outstanding read, released by RREADY
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Capture read data at the AR handshake so it stays stable while RVALID waits
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
    end
  end

  conv_axil_regfile #(
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk    (S_AXI_ACLK),
    .resetn (S_AXI_ARESETN),
    .wr_en  (wr_commit),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_conv_axil_responder.sv
// tb/tb_conv_axil_responder.sv - directed self-checking bench for conv_axil_responder
module tb_conv_axil_responder;

  logic        tb_ACLK;
  logic        S_AXI_ARESETN;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  int checks = 0;
  int errors = 0;

  conv_axil_responder dut (
    .S_AXI_ACLK   (tb_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_f, w_f, got;
    resp = 2'bxx;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20 && (S_AXI_AWVALID || S_AXI_WVALID); i++) begin
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_f) S_AXI_AWVALID = 1'b0;
      if (w_f)  S_AXI_WVALID  = 1'b0;
    end
    checks++;
    if (S_AXI_AWVALID || S_AXI_WVALID) begin
      errors++;
      $display("FAIL write_accept: addr %h aw_pending=%0b w_pending=%0b, required both accepted within 20 cycles",
               addr, S_AXI_AWVALID, S_AXI_WVALID);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
    S_AXI_BREADY = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (S_AXI_BVALID) begin
        resp = S_AXI_BRESP;
        got  = 1'b1;
      end
      tick();
    end
    S_AXI_BREADY = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL write_bvalid: addr %h no BVALID within 20 cycles, required a response", addr);
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    logic ar_f, got;
    data = 'x;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20 && S_AXI_ARVALID; i++) begin
      ar_f = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      if (ar_f) S_AXI_ARVALID = 1'b0;
    end
    checks++;
    if (S_AXI_ARVALID) begin
      errors++;
      $display("FAIL read_accept: addr %h not accepted within 20 cycles", addr);
      S_AXI_ARVALID = 1'b0;
    end
    S_AXI_RREADY = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (S_AXI_RVALID) begin
        data = S_AXI_RDATA;
        got  = 1'b1;
      end
      tick();
    end
    S_AXI_RREADY = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_rvalid: addr %h no RVALID within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: aw/w/b/ar/r = %b, required 00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end
    checks++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
      errors++;
      $display("FAIL reset_payload: bresp=%b rresp=%b rdata=%h, required 0/0/0",
               S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
    end
    S_AXI_ARESETN = 1'b1;
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: aw/w/ar ready = %b, required 111",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd;
    S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    checks++;
    if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin
      errors++;
      $display("FAIL wfirst_latched: wready/awready/bvalid = %b, required 010",
               {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID});
    end
    tick();
    S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin
      errors++;
      $display("FAIL wfirst_bresp: bvalid=%b bresp=%b, required 1/00", S_AXI_BVALID, S_AXI_BRESP);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    axi_read(6'h0C, rd);
    checks++;
    if (rd !== 32'h0022_0044) begin
      errors++;
      $display("FAIL wfirst_strobe_data: read 0x0C = %h, required 00220044", rd);
    end
    axi_read(6'h38, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL wfirst_counter: reg14 = %h, required 00000001", rd);
    end
  endtask

  task automatic test_same_cycle();
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) begin
      errors++;
      $display("FAIL same_cycle_b: bvalid=%b bresp=%b awready=%b wready=%b, required 1/00/0/0",
               S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin
      errors++;
      $display("FAIL same_cycle_bclear: bvalid=%b awready=%b, required 0/1", S_AXI_BVALID, S_AXI_AWREADY);
    end
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++;
    if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      errors++;
      $display("FAIL same_cycle_read: rvalid=%b rdata=%h rresp=%b, required 1/deadbeef/00",
               S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    checks++;
    if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin
      errors++;
      $display("FAIL same_cycle_rclear: rvalid=%b arready=%b, required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_slverr();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h3C, 32'h1234_5678, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("FAIL slverr_id_bresp: bresp=%b, required 10", resp);
    end
    axi_write(6'h38, 32'hFFFF_0000, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("FAIL slverr_cnt_bresp: bresp=%b, required 10", resp);
    end
    axi_read(6'h3C, rd);
    checks++;
    if (rd !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL slverr_id_read: reg15 = %h, required c0de0001", rd);
    end
    axi_read(6'h38, rd);
    checks++;
    if (rd !== 32'd2) begin
      errors++;
      $display("FAIL slverr_counter: reg14 = %h, required 00000002", rd);
    end
  endtask

  task automatic test_strobe_zero();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h08, 32'h0000_0000, 4'b0000, resp);
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL strb0_bresp: bresp=%b, required 00", resp);
    end
    axi_read(6'h08, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL strb0_data: reg2 = %h, required deadbeef", rd);
    end
    axi_read(6'h38, rd);
    checks++;
    if (rd !== 32'd3) begin
      errors++;
      $display("FAIL strb0_counter: reg14 = %h, required 00000003", rd);
    end
  endtask

  task automatic test_backpressure();
    S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'hA5A5_5A5A; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) begin
        errors++;
        $display("FAIL bstall_cycle%0d: bvalid=%b bresp=%b awready=%b wready=%b, required 1/00/0/0",
                 i, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
      end
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 6'h10; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY} !== {1'b1, 32'hA5A5_5A5A, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL rstall_cycle%0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1/a5a55a5a/00/0",
                 i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
      end
      tick();
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
      errors++;
      $display("FAIL stall_release: bvalid=%b rvalid=%b, required 0/0", S_AXI_BVALID, S_AXI_RVALID);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h04, 32'h1234_5678, 4'hF, resp);
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 6'h04;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== {2'b11, 32'h1234_5678}) begin
      errors++;
      $display("FAIL concurrent_prewrite: bvalid=%b rvalid=%b rdata=%h, required 1/1/12345678",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    axi_read(6'h04, rd);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL concurrent_postwrite: reg1 = %h, required cafef00d", rd);
    end
    axi_read(6'h38, rd);
    checks++;
    if (rd !== 32'd6) begin
      errors++;
      $display("FAIL concurrent_counter: reg14 = %h, required 00000006", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  resp;
    logic [31:0] rd;
    axi_write(6'h00, 32'h0000_0055, 4'hF, resp);
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h7777_7777; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 6'h00;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== {2'b11, 32'h0000_0055}) begin
      errors++;
      $display("FAIL midreset_setup: bvalid=%b rvalid=%b rdata=%h, required 1/1/00000055",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
    end
    S_AXI_ARESETN = 1'b0;
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
         S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 41'h0) begin
      errors++;
      $display("FAIL midreset_outputs: aw/w/b/ar/r=%b bresp=%b rresp=%b rdata=%h, required all 0",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID},
               S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
    end
    S_AXI_ARESETN = 1'b1;
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
      errors++;
      $display("FAIL midreset_release: aw/w/ar/b/r = %b, required 11100",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    axi_read(6'h00, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL midreset_reg0: reg0 = %h, required 00000000", rd);
    end
    axi_read(6'h38, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL midreset_counter: reg14 = %h, required 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_same_cycle();
    test_slverr();
    test_strobe_zero();
    test_backpressure();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_axil_responder.md
CONV_AXIL_RESPONDER -- requirements
Module: conv_axil_responder

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width giving 16 word registers.
REQ-003 Parameter ID_VALUE, default 32'hC0DE_0001, value returned by register 15.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-009 S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.

Function
REQ-011 The block SHALL be the AXI4-Lite responder for the Convolution_Tester M00_AXI master: 16 x 32-bit registers, word index = ADDR[5:2], ADDR[1:0] ignored.
REQ-012 Map: regs 0-13 read/write; reg 14 read-only write counter; reg 15 read-only ID_VALUE.
REQ-013 Write FSM states W_IDLE, W_RESP; AWREADY high in W_IDLE while no address is latched, WREADY high in W_IDLE while no data is latched.
REQ-014 AW and W SHALL be accepted in either order or in the same cycle; each latched independently; READY drops for a channel once it is latched.
REQ-015 The cycle after both are latched: register update commits, BVALID rises, FSM -> W_RESP; write latency from last handshake to BVALID = 1 cycle.
REQ-016 Write to regs 0-13: byte lane n updated only where WSTRB[n]=1; BRESP=OKAY (2'b00); counter reg 14 increments by 1, wrapping 0xFFFFFFFF -> 0.
REQ-017 Write to reg 14 or 15: no register change, counter unchanged, BRESP=SLVERR (2'b10).
REQ-018 BVALID/BRESP SHALL hold stable until BREADY=1; on that handshake BVALID clears, latches clear, FSM -> W_IDLE; no new AW/W accepted in W_RESP.
REQ-019 Read FSM states R_IDLE, R_DATA; ARREADY high only in R_IDLE.
REQ-020 AR handshake: RDATA loaded from addressed register at that edge, RVALID rises next cycle (latency 1), RRESP=OKAY for all indices, FSM -> R_DATA.
REQ-021 RVALID/RDATA SHALL hold stable until RREADY=1; then RVALID clears, FSM -> R_IDLE; next ARREADY asserted the following cycle.
REQ-022 Read and write channels SHALL operate concurrently; read sampled on the same edge a write commits to that register returns the pre-write value.
REQ-023 WSTRB=4'b0000 to RW register: OKAY, counter increments, data unchanged.

Reset
REQ-024 While S_AXI_ARESETN=0 at a rising edge: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0; regs 0-14 = 0; both FSMs -> idle; latches cleared.
REQ-025 Reset mid-transaction SHALL abandon it silently; READY outputs assert the first cycle after release.

Structure
REQ-026 Shared package conv_axil_pkg holds RESP_OKAY, RESP_SLVERR, REG_CNT_IDX=14, REG_ID_IDX=15, NUM_REGS=16 and FSM state encodings.
REQ-027 One sub-module, conv_axil_regfile (16x32, strobed write port, one combinational read port, counter increment); FSMs live in the top.

Verification
REQ-028 AW and W same cycle, addr 0x08, data 0xDEADBEEF, strb 4'hF -> BVALID 1 cycle later, BRESP=00; read 0x08 -> RDATA 0xDEADBEEF, RVALID 1 cycle after AR.
REQ-029 W 2 cycles before AW, addr 0x0C data 0x11223344 strb 4'b0101 over 0 -> read 0x0C = 0x00220044; read 0x38 = 1 after first write on fresh reset.
REQ-030 Write 0x3C -> BRESP=10, read 0x3C = 0xC0DE0001, reg 14 unchanged.
REQ-031 BREADY held low 5 cycles, RREADY low 5 cycles -> BVALID/RVALID and payload stable throughout, AWREADY/ARREADY low throughout.
REQ-032 Reset asserted during W_RESP and R_DATA -> all outputs 0 next edge; post-reset read of reg 0 returns 0.
